// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit and receive paths.
//   tx_state_e  - transmitter frame state encoding
//   PARITY_*    - meaning of the parity_type control bit
//   LINE_IDLE, START_BIT, STOP_BIT - serial line levels
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: word-level handshake into the UART transmitter.
//   parallel_data  - word to transmit
//   data_valid     - parallel_data is valid this cycle
//   parity_type    - 1 = odd, 0 = even (captured with the word)
//   parity_enable  - 1 = frame carries a parity bit (captured with the word)
//   ready          - transmitter can take a word this cycle
// master: the word producer; slave: the transmitter.
interface uart_transmitter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  data_valid;
    logic                  parity_type;
    logic                  parity_enable;
    logic                  ready;

    modport master (
        output parallel_data,
        output data_valid,
        output parity_type,
        output parity_enable,
        input  ready
    );

    modport slave (
        input  parallel_data,
        input  data_valid,
        input  parity_type,
        input  parity_enable,
        output ready
    );
endinterface

// File: rtl/uart_transmitter_parity_calculator.sv
// parity_calculator: combinational parity bit for a UART word.
//   data        - word whose bits are covered by the parity bit
//   parity_type - PARITY_EVEN or PARITY_ODD
//   parity_bit  - bit that makes the total count of ones even (or odd)
// Shared between the transmitter and the receive-side parity checker.
module parity_calculator
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  parity_type,
    output logic                  parity_bit
);

    // XOR reduction of the word: 1 when the word holds an odd number of ones.
    function automatic logic xor_reduce(input logic [DATA_WIDTH-1:0] d);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            acc = acc ^ d[i];
        end
        return acc;
    endfunction

    logic data_xor_s;

    assign data_xor_s = xor_reduce(data);
    assign parity_bit = (parity_type == PARITY_EVEN) ? data_xor_s : ~data_xor_s;

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serial UART transmitter, one line bit per clk cycle.
//   clk          - bit-rate clock
//   reset        - synchronous active-high reset
//   tx           - word handshake (slave side) with per-word parity controls
//   serial_data  - registered serial line, idle high
//   busy         - a frame is being shifted out
// Frame: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// One word can wait in the holding register behind the frame in flight; it
// is started straight after the stop bit with no idle gap.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_transmitter_if.slave    tx,
    output logic                 serial_data,
    output logic                 busy
);

    localparam int              IDX_W    = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_e             state_r, state_s;
    logic [IDX_W-1:0]      index_r, index_s;
    logic [DATA_WIDTH-1:0] word_r, word_s;
    logic                  pen_r, pen_s;
    logic                  ptype_r, ptype_s;
    logic [DATA_WIDTH-1:0] hold_data_r, hold_data_s;
    logic                  hold_pen_r, hold_pen_s;
    logic                  hold_ptype_r, hold_ptype_s;
    logic                  hold_full_r, hold_full_s;
    logic                  serial_r, serial_s;
    logic                  busy_r, busy_s;
    logic                  ready_r, ready_s;
    logic                  accept_s;
    logic                  parity_bit_s;

    assign accept_s    = tx.data_valid & ready_r;
    assign tx.ready    = ready_r;
    assign serial_data = serial_r;
    assign busy        = busy_r;

    parity_calculator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data        (word_r),
        .parity_type (ptype_r),
        .parity_bit  (parity_bit_s)
    );

    // State, frame word and output registers; reset abandons any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            index_r      <= '0;
            word_r       <= '0;
            pen_r        <= 1'b0;
            ptype_r      <= 1'b0;
            hold_data_r  <= '0;
            hold_pen_r   <= 1'b0;
            hold_ptype_r <= 1'b0;
            hold_full_r  <= 1'b0;
            serial_r     <= LINE_IDLE;
            busy_r       <= 1'b0;
            ready_r      <= 1'b1;
        end else begin
            state_r      <= state_s;
            index_r      <= index_s;
            word_r       <= word_s;
            pen_r        <= pen_s;
            ptype_r      <= ptype_s;
            hold_data_r  <= hold_data_s;
            hold_pen_r   <= hold_pen_s;
            hold_ptype_r <= hold_ptype_s;
            hold_full_r  <= hold_full_s;
            serial_r     <= serial_s;
            busy_r       <= busy_s;
            ready_r      <= ready_s;
        end
    end

    // Next-state, holding register and next line level.
    always_comb begin
        state_s      = state_r;
        index_s      = index_r;
        word_s       = word_r;
        pen_s        = pen_r;
        ptype_s      = ptype_r;
        hold_data_s  = hold_data_r;
        hold_pen_s   = hold_pen_r;
        hold_ptype_s = hold_ptype_r;
        hold_full_s  = hold_full_r;
        serial_s     = LINE_IDLE;

        // A word arriving mid-frame waits in the holding register.
        if (accept_s && ((state_r == START) || (state_r == DATA) || (state_r == PARITY))) begin
            hold_data_s  = tx.parallel_data;
            hold_pen_s   = tx.parity_enable;
            hold_ptype_s = tx.parity_type;
            hold_full_s  = 1'b1;
        end else begin
            hold_full_s  = hold_full_r;
        end

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = START;
                    word_s  = tx.parallel_data;
                    pen_s   = tx.parity_enable;
                    ptype_s = tx.parity_type;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                state_s = DATA;
                index_s = '0;
            end
            DATA: begin
                if (index_r == LAST_IDX) begin
                    state_s = pen_r ? PARITY : STOP;
                end else begin
                    index_s = index_r + 1'b1;
                end
            end
            PARITY: begin
                state_s = STOP;
            end
            STOP: begin
                // Held word wins; otherwise a same-cycle accept bypasses the
                // holding register so the line never idles between frames.
                if (hold_full_r) begin
                    state_s     = START;
                    word_s      = hold_data_r;
                    pen_s       = hold_pen_r;
                    ptype_s     = hold_ptype_r;
                    hold_full_s = 1'b0;
                end else if (accept_s) begin
                    state_s = START;
                    word_s  = tx.parallel_data;
                    pen_s   = tx.parity_enable;
                    ptype_s = tx.parity_type;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Line level follows the next state so both registers move together.
        // Parity uses the current word: entering PARITY never reloads it.
        case (state_s)
            IDLE:    serial_s = LINE_IDLE;
            START:   serial_s = START_BIT;
            DATA:    serial_s = word_s[index_s];
            PARITY:  serial_s = parity_bit_s;
            STOP:    serial_s = STOP_BIT;
            default: serial_s = LINE_IDLE;
        endcase
    end

    assign busy_s  = (state_s != IDLE);
    assign ready_s = ~hold_full_s;

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    logic serial_data;
    logic busy;

    uart_transmitter_if #(.DATA_WIDTH(DW)) tx_if ();

    uart_transmitter #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx          (tx_if.slave),
        .serial_data (serial_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: the line is the concatenation of the frames of every
    // accepted word, idle-high when nothing is queued.
    bit   line_q[$];
    int   frame_len_q[$];
    int   cur_rem;
    logic exp_serial;
    logic exp_busy;
    logic exp_ready;

    task automatic model_push(input logic [DW-1:0] w, input logic pen, input logic pt);
        line_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) line_q.push_back(w[i]);
        if (pen) line_q.push_back((($countones(w) % 2) == 1) ^ pt);
        line_q.push_back(1'b1);
        frame_len_q.push_back(DW + 2 + int'(pen));
    endtask

    // Advance one clock, updating the model with what the DUT saw at the edge.
    task automatic clock_cycle();
        logic          acc;
        logic          rst;
        logic [DW-1:0] w;
        logic          pen;
        logic          pt;
        rst = reset;
        acc = tx_if.data_valid && exp_ready;
        w   = tx_if.parallel_data;
        pen = tx_if.parity_enable;
        pt  = tx_if.parity_type;
        @(posedge clk);
        #1;
        if (rst) begin
            line_q.delete();
            frame_len_q.delete();
            cur_rem    = 0;
            exp_serial = 1'b1;
            exp_busy   = 1'b0;
            exp_ready  = 1'b1;
        end else begin
            if (acc) model_push(w, pen, pt);
            if (line_q.size() > 0) begin
                if (cur_rem == 0) cur_rem = frame_len_q.pop_front();
                exp_serial = line_q.pop_front();
                cur_rem--;
                exp_busy = 1'b1;
            end else begin
                exp_serial = 1'b1;
                exp_busy   = 1'b0;
            end
            exp_ready = (frame_len_q.size() == 0);
        end
    endtask

    task automatic set_word(input logic v, input logic [DW-1:0] d, input logic pen, input logic pt);
        tx_if.data_valid    = v;
        tx_if.parallel_data = d;
        tx_if.parity_enable = pen;
        tx_if.parity_type   = pt;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_word(1'b0, 8'h00, 1'b0, 1'b0);
        clock_cycle();
        clock_cycle();
        reset = 1'b0;
        checks++;
        if (serial_data !== 1'b1 || busy !== 1'b0 || tx_if.ready !== 1'b1) begin
            $display("FAIL reset_state: serial=%b busy=%b ready=%b required 1 0 1", serial_data, busy, tx_if.ready);
        end else passes++;
        for (int c = 0; c < 20; c++) begin
            clock_cycle();
            checks++;
            if (serial_data !== 1'b1 || busy !== 1'b0 || tx_if.ready !== 1'b1) begin
                $display("FAIL idle_cycle%0d: serial=%b busy=%b ready=%b required 1 0 1", c, serial_data, busy, tx_if.ready);
            end else passes++;
        end
    endtask

    task automatic test_frame_no_parity();
        logic [10:0] seq;
        logic [10:0] bsy;
        seq = 11'b1_1101001010;   // sample k is bit k-1: 0,1,0,1,0,0,1,0,1,1 then idle 1
        bsy = 11'b0_1111111111;
        set_word(1'b1, 8'hA5, 1'b0, 1'b0);
        for (int s = 1; s <= 11; s++) begin
            clock_cycle();
            if (s == 1) set_word(1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (serial_data !== seq[s-1] || busy !== bsy[s-1]) begin
                $display("FAIL a5_frame_s%0d: serial=%b busy=%b required %b %b", s, serial_data, busy, seq[s-1], bsy[s-1]);
            end else passes++;
            checks++;
            if (serial_data !== exp_serial || busy !== exp_busy || tx_if.ready !== exp_ready) begin
                $display("FAIL a5_model_s%0d: serial=%b busy=%b ready=%b required %b %b %b", s, serial_data, busy, tx_if.ready, exp_serial, exp_busy, exp_ready);
            end else passes++;
        end
    endtask

    task automatic test_parity();
        for (int pt = 0; pt < 2; pt++) begin
            int busy_cnt = 0;
            set_word(1'b1, 8'hA5, 1'b1, 1'(pt));
            for (int s = 1; s <= 12; s++) begin
                clock_cycle();
                if (s == 1) set_word(1'b0, 8'hFF, 1'b0, ~1'(pt));
                if (busy === 1'b1) busy_cnt++;
                if (s == 10) begin
                    checks++;
                    if (serial_data !== 1'(pt)) begin
                        $display("FAIL parity_bit_type%0d: serial=%b required %b", pt, serial_data, 1'(pt));
                    end else passes++;
                end
                if (s == 11) begin
                    checks++;
                    if (serial_data !== 1'b1 || busy !== 1'b1) begin
                        $display("FAIL parity_stop_type%0d: serial=%b busy=%b required 1 1", pt, serial_data, busy);
                    end else passes++;
                end
                checks++;
                if (serial_data !== exp_serial || busy !== exp_busy || tx_if.ready !== exp_ready) begin
                    $display("FAIL parity_model_t%0d_s%0d: serial=%b busy=%b ready=%b required %b %b %b", pt, s, serial_data, busy, tx_if.ready, exp_serial, exp_busy, exp_ready);
                end else passes++;
            end
            checks++;
            if (busy_cnt != 11) begin
                $display("FAIL parity_frame_len_type%0d: busy cycles=%0d required 11", pt, busy_cnt);
            end else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0;
        set_word(1'b1, 8'h3C, 1'b0, 1'b0);
        for (int s = 1; s <= 26; s++) begin
            if (s == 2)  set_word(1'b0, 8'h00, 1'b0, 1'b0);
            if (s == 4)  set_word(1'b1, 8'hFF, 1'b0, 1'b0);
            if (s == 5)  set_word(1'b1, 8'h55, 1'b1, 1'b1);
            if (s == 10) set_word(1'b0, DW'($urandom), 1'b1, 1'b0);
            clock_cycle();
            if (busy === 1'b1) busy_cnt++;
            if (s >= 4 && s <= 10) begin
                checks++;
                if (tx_if.ready !== 1'b0) begin
                    $display("FAIL b2b_ready_low_s%0d: ready=%b required 0", s, tx_if.ready);
                end else passes++;
            end
            if (s == 11) begin
                checks++;
                if (serial_data !== 1'b0 || tx_if.ready !== 1'b1) begin
                    $display("FAIL b2b_second_start: serial=%b ready=%b required 0 1", serial_data, tx_if.ready);
                end else passes++;
            end
            checks++;
            if (serial_data !== exp_serial || busy !== exp_busy || tx_if.ready !== exp_ready) begin
                $display("FAIL b2b_model_s%0d: serial=%b busy=%b ready=%b required %b %b %b", s, serial_data, busy, tx_if.ready, exp_serial, exp_busy, exp_ready);
            end else passes++;
        end
        checks++;
        if (busy_cnt != 20) begin
            $display("FAIL b2b_busy_cycles: busy cycles=%0d required 20", busy_cnt);
        end else passes++;
    endtask

    task automatic test_bypass();
        set_word(1'b1, 8'h80, 1'b0, 1'b0);
        for (int s = 1; s <= 22; s++) begin
            if (s == 2)  set_word(1'b0, 8'h00, 1'b0, 1'b0);
            if (s == 11) set_word(1'b1, 8'h01, 1'b0, 1'b0);
            if (s == 12) set_word(1'b0, 8'h00, 1'b0, 1'b0);
            clock_cycle();
            if (s == 10 || s == 11) begin
                checks++;
                if (serial_data !== (s == 10) || busy !== 1'b1 || tx_if.ready !== 1'b1) begin
                    $display("FAIL bypass_s%0d: serial=%b busy=%b ready=%b required %b 1 1", s, serial_data, busy, tx_if.ready, (s == 10));
                end else passes++;
            end
            checks++;
            if (serial_data !== exp_serial || busy !== exp_busy || tx_if.ready !== exp_ready) begin
                $display("FAIL bypass_model_s%0d: serial=%b busy=%b ready=%b required %b %b %b", s, serial_data, busy, tx_if.ready, exp_serial, exp_busy, exp_ready);
            end else passes++;
        end
    endtask

    task automatic test_reset_mid_frame();
        set_word(1'b1, 8'hC3, 1'b1, 1'b0);
        for (int s = 1; s <= 25; s++) begin
            if (s == 2) set_word(1'b1, 8'h5A, 1'b0, 1'b1);
            if (s == 3) set_word(1'b0, 8'h00, 1'b0, 1'b0);
            if (s == 6) reset = 1'b1;
            if (s == 7) reset = 1'b0;
            clock_cycle();
            if (s == 5) begin
                checks++;
                if (tx_if.ready !== 1'b0 || serial_data !== 1'b0) begin
                    $display("FAIL rst_mid_setup: ready=%b serial=%b required 0 0", tx_if.ready, serial_data);
                end else passes++;
            end
            if (s >= 6) begin
                checks++;
                if (serial_data !== 1'b1 || busy !== 1'b0 || tx_if.ready !== 1'b1) begin
                    $display("FAIL rst_mid_s%0d: serial=%b busy=%b ready=%b required 1 0 1", s, serial_data, busy, tx_if.ready);
                end else passes++;
            end
            checks++;
            if (serial_data !== exp_serial || busy !== exp_busy || tx_if.ready !== exp_ready) begin
                $display("FAIL rst_mid_model_s%0d: serial=%b busy=%b ready=%b required %b %b %b", s, serial_data, busy, tx_if.ready, exp_serial, exp_busy, exp_ready);
            end else passes++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (c < 560) begin
                set_word(($urandom_range(0, 2) == 0), DW'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                set_word(1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
            end
            clock_cycle();
            checks++;
            if (serial_data !== exp_serial || busy !== exp_busy || tx_if.ready !== exp_ready) begin
                $display("FAIL random_c%0d: serial=%b busy=%b ready=%b required %b %b %b", c, serial_data, busy, tx_if.ready, exp_serial, exp_busy, exp_ready);
            end else passes++;
        end
    endtask

    initial begin
        cur_rem    = 0;
        exp_serial = 1'b1;
        exp_busy   = 1'b0;
        exp_ready  = 1'b1;
        reset      = 1'b1;
        set_word(1'b0, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_frame_no_parity();
        test_parity();
        test_back_to_back();
        test_bypass();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
